// File: rtl/i2c_slave_reg_ctrl_if.sv
// rtl/i2c_slave_reg_ctrl_if.sv - RX/TX byte streams and register access bus of the I2C register controller
interface i2c_slave_reg_ctrl_if;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tlast;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tlast;
  logic       tx_tready;
  logic       bus_addressed;
  logic [7:0] reg_addr;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       err_timeout;

  modport slave (
    input  rx_tdata, rx_tvalid, rx_tlast, tx_tready, bus_addressed, reg_rdata, reg_ack,
    output rx_tready, tx_tdata, tx_tvalid, tx_tlast, reg_addr, reg_wr, reg_rd, reg_wdata,
           err_timeout
  );

  modport master (
    output rx_tdata, rx_tvalid, rx_tlast, tx_tready, bus_addressed, reg_rdata, reg_ack,
    input  rx_tready, tx_tdata, tx_tvalid, tx_tlast, reg_addr, reg_wr, reg_rd, reg_wdata,
           err_timeout
  );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// rtl/i2c_slave_reg_ctrl.sv - I2C slave byte stream to register bus bridge with pointer and access timeout
// Optional feature: define I2C_REG_CTRL_AUTOINC_EN to advance the pointer after every data access.
module i2c_slave_reg_ctrl #(
  parameter int unsigned TIMEOUT = 1000
) (
  input logic                   clk,
  input logic                   rst,
  i2c_slave_reg_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_WAIT, RD_WAIT, TX_HOLD} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
`ifdef I2C_REG_CTRL_AUTOINC_EN
  localparam logic [7:0] PTR_STEP = 8'd1;
`else
  localparam logic [7:0] PTR_STEP = 8'd0;
`endif

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  txd_q, txd_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rdy_en_q;

  logic rx_tready_w;
  logic rx_beat;
  logic timeout_w;

  // rdy_en_q keeps rx_tready low for the first cycle out of reset
  assign rx_tready_w = rdy_en_q && (state_q == IDLE || state_q == WR_DATA);
  assign rx_beat     = bus.rx_tvalid && rx_tready_w;
  assign timeout_w   = (state_q == WR_WAIT || state_q == RD_WAIT) && !bus.reg_ack
                       && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_beat) begin
          ptr_d = bus.rx_tdata;
          if (!bus.rx_tlast) state_d = WR_DATA;
        end else if (rdy_en_q && bus.tx_tready) begin
          state_d = RD_WAIT;
          cnt_d   = 16'd0;
        end
      end
      WR_DATA: begin
        if (rx_beat) begin
          wdata_d = bus.rx_tdata;
          last_d  = bus.rx_tlast;
          state_d = WR_WAIT;
          cnt_d   = 16'd0;
        end
      end
      WR_WAIT: begin
        if (bus.reg_ack || timeout_w) begin
          ptr_d   = ptr_q + PTR_STEP;
          err_d   = timeout_w;
          state_d = last_q ? IDLE : WR_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RD_WAIT: begin
        if (bus.reg_ack) begin
          txd_d   = bus.reg_rdata;
          state_d = TX_HOLD;
        end else if (timeout_w) begin
          txd_d   = 8'hFF;
          err_d   = 1'b1;
          state_d = TX_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_HOLD: begin
        if (bus.tx_tready) begin
          ptr_d   = ptr_q + PTR_STEP;
          state_d = IDLE;
        end else if (!bus.bus_addressed) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 8'h00;
      wdata_q  <= 8'h00;
      txd_q    <= 8'h00;
      last_q   <= 1'b0;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wdata_q  <= wdata_d;
      txd_q    <= txd_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Request strobes come straight from the state, so they are exclusive by construction
  assign bus.rx_tready   = rx_tready_w;
  assign bus.tx_tdata    = txd_q;
  assign bus.tx_tvalid   = (state_q == TX_HOLD);
  assign bus.tx_tlast    = 1'b0;
  assign bus.reg_addr    = ptr_q;
  assign bus.reg_wr      = (state_q == WR_WAIT);
  assign bus.reg_rd      = (state_q == RD_WAIT);
  assign bus.reg_wdata   = wdata_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// tb/tb_i2c_slave_reg_ctrl.sv - directed and random bench for i2c_slave_reg_ctrl against a pointer/memory model
module tb_i2c_slave_reg_ctrl;

  localparam int TO = 8;
`ifdef I2C_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_reg_ctrl_if bus();
  i2c_slave_reg_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current pointer and register contents as the spec defines them
  logic [7:0] ref_ptr;
  logic [7:0] ref_mem [256];
  // Register file the bench emulates on the DUT's register bus
  logic [7:0] dev_mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int w = 0;
    bus.rx_tdata  = d;
    bus.rx_tvalid = 1'b1;
    bus.rx_tlast  = last;
    while (bus.rx_tready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rx_accept_in_time", 32'(w < 20), 32'd1);
    @(negedge clk);
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
  endtask

  task automatic serve_write(input logic [7:0] exp_data, input int lat);
    check("wr_data", 32'(bus.reg_wdata), 32'(exp_data));
    for (int i = 0; i <= lat; i++) begin
      check("wr_strobes", 32'({bus.reg_wr, bus.reg_rd}), 32'b10);
      check("wr_addr", 32'(bus.reg_addr), 32'(ref_ptr));
      if (i == lat) begin
        bus.reg_ack = 1'b1;
        dev_mem[bus.reg_addr] = bus.reg_wdata;
      end
      @(negedge clk);
    end
    bus.reg_ack = 1'b0;
    ref_mem[ref_ptr] = exp_data;
    if (AUTOINC) ref_ptr++;
  endtask

  task automatic write_burst(input logic [7:0] p, input logic [7:0] data[$], input int lat);
    send_beat(p, data.size() == 0);
    ref_ptr = p;
    foreach (data[k]) begin
      send_beat(data[k], k == data.size() - 1);
      serve_write(data[k], lat);
    end
    check("wr_idle_strobes", 32'({bus.reg_wr, bus.reg_rd}), 32'b00);
    check("ptr_after_wr", 32'(bus.reg_addr), 32'(ref_ptr));
  endtask

  task automatic do_read(input int lat, input bit tmo, input int hold, input bit abort);
    logic [7:0] exp;
    exp = tmo ? 8'hFF : ref_mem[ref_ptr];
    bus.tx_tready = 1'b1;
    @(negedge clk);
    bus.tx_tready = 1'b0;
    if (tmo) begin
      for (int i = 0; i < TO; i++) begin
        check("rd_strobes_tmo", 32'({bus.reg_wr, bus.reg_rd}), 32'b01);
        check("rd_addr_tmo", 32'(bus.reg_addr), 32'(ref_ptr));
        check("err_early", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
      end
      check("err_pulse", 32'(bus.err_timeout), 32'd1);
    end else begin
      for (int i = 0; i <= lat; i++) begin
        check("rd_strobes", 32'({bus.reg_wr, bus.reg_rd}), 32'b01);
        check("rd_addr", 32'(bus.reg_addr), 32'(ref_ptr));
        if (i == lat) begin
          bus.reg_ack   = 1'b1;
          bus.reg_rdata = dev_mem[bus.reg_addr];
        end
        @(negedge clk);
      end
      bus.reg_ack = 1'b0;
      check("err_quiet", 32'(bus.err_timeout), 32'd0);
    end
    check("rd_done", 32'(bus.reg_rd), 32'd0);
    check("tx_valid", 32'(bus.tx_tvalid), 32'd1);
    check("tx_data", 32'(bus.tx_tdata), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("tx_hold_valid", 32'(bus.tx_tvalid), 32'd1);
      check("tx_hold_data", 32'(bus.tx_tdata), 32'(exp));
      check("err_one_cycle", 32'(bus.err_timeout), 32'd0);
    end
    if (abort) begin
      bus.bus_addressed = 1'b0;
      @(negedge clk);
      bus.bus_addressed = 1'b1;
      check("tx_abort_valid", 32'(bus.tx_tvalid), 32'd0);
      check("tx_abort_ptr", 32'(bus.reg_addr), 32'(ref_ptr));
    end else begin
      bus.tx_tready = 1'b1;
      @(negedge clk);
      bus.tx_tready = 1'b0;
      if (AUTOINC) ref_ptr++;
      check("tx_done_valid", 32'(bus.tx_tvalid), 32'd0);
      check("ptr_after_rd", 32'(bus.reg_addr), 32'(ref_ptr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bus.rx_tdata = 8'h00; bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0;
    bus.tx_tready = 1'b0; bus.bus_addressed = 1'b1;
    bus.reg_rdata = 8'h00; bus.reg_ack = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i);
      dev_mem[i] = 8'(i);
    end
    ref_ptr = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_rx_tready", 32'(bus.rx_tready), 32'd0);
    check("rst_tx_tvalid", 32'(bus.tx_tvalid), 32'd0);
    check("rst_tx_tdata", 32'(bus.tx_tdata), 32'h00);
    check("rst_strobes", 32'({bus.reg_wr, bus.reg_rd}), 32'b00);
    check("rst_wdata", 32'(bus.reg_wdata), 32'h00);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_ptr", 32'(bus.reg_addr), 32'h00);
    rst = 1'b0;
    check("rx_tready_low_at_release", 32'(bus.rx_tready), 32'd0);
    @(negedge clk);
    check("rx_tready_after_release", 32'(bus.rx_tready), 32'd1);

    // Pointer 0x10, two data bytes, ack on the third request cycle
    q = '{8'hA5, 8'h5A};
    write_burst(8'h10, q, 2);
    check("wr_burst_ptr", 32'(bus.reg_addr), AUTOINC ? 32'h12 : 32'h10);

    // Pointer-only write then three reads that wrap the pointer
    q = {};
    write_burst(8'hFE, q, 0);
    for (int r = 0; r < 3; r++) do_read(r, 1'b0, r, 1'b0);
    check("wrap_ptr", 32'(bus.reg_addr), AUTOINC ? 32'h01 : 32'hFE);

    // Read timeout with no acknowledge
    do_read(0, 1'b1, 1, 1'b0);

    // RX beat and read request together: beat wins, taken as pointer
    bus.rx_tdata = 8'h33; bus.rx_tvalid = 1'b1; bus.rx_tlast = 1'b1;
    bus.tx_tready = 1'b1;
    @(negedge clk);
    bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.tx_tready = 1'b0;
    ref_ptr = 8'h33;
    check("both_no_rd", 32'(bus.reg_rd), 32'd0);
    check("both_ptr", 32'(bus.reg_addr), 32'h33);
    @(negedge clk);
    check("both_still_no_rd", 32'(bus.reg_rd), 32'd0);

    // Master releases the bus while the byte is held
    do_read(1, 1'b0, 0, 1'b1);

    // Random write bursts and reads against the model
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        q = {};
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) q.push_back(8'($urandom));
        write_burst(8'($urandom), q, int'($urandom_range(0, 4)));
      end else begin
        do_read(int'($urandom_range(0, 4)), 1'b0, int'($urandom_range(0, 2)), 1'b0);
      end
    end

    // Reset in the middle of a write access
    send_beat(8'h40, 1'b0);
    send_beat(8'hC3, 1'b0);
    check("pre_rst_wr", 32'(bus.reg_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 8'h00;
    check("rst_abort_wr", 32'(bus.reg_wr), 32'd0);
    check("rst_abort_ptr", 32'(bus.reg_addr), 32'h00);
    check("rst_abort_rx_tready", 32'(bus.rx_tready), 32'd0);
    @(negedge clk);
    check("rst_abort_recover", 32'(bus.rx_tready), 32'd1);
    do_read(0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
